// File: rtl/bcd_countdown.sv
// Two-digit BCD down-counter (99..00) with preset load, start/stop control,
// per-tick decrement, a one-cycle done pulse and optional auto-reload.
module bcd_countdown #(
  parameter bit RELOAD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,        // asynchronous, active-low
  input  logic       load,
  input  logic [3:0] preset_tens,
  input  logic [3:0] preset_ones,
  input  logic       start,
  input  logic       stop,
  input  logic       en,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e     state_q, state_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] pre_t_q, pre_t_d;
  logic [3:0] pre_o_q, pre_o_d;

  logic [3:0] load_t, load_o;
  logic [3:0] dec_t, dec_o;
  logic       cnt_zero, cnt_one, pre_zero;

  // Out-of-range BCD digits saturate to 9 so only 0-9 ever reach the display.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Clamped preset digits and count/preset decode flags.
  always_comb begin
    load_t   = clamp_digit(preset_tens);
    load_o   = clamp_digit(preset_ones);
    cnt_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
    cnt_one  = (tens_q == 4'd0) && (ones_q == 4'd1);
    pre_zero = (pre_t_q == 4'd0) && (pre_o_q == 4'd0);
  end

  // BCD decrement with borrow from tens; saturates at 00.
  always_comb begin
    dec_t = tens_q;
    dec_o = ones_q;
    if (ones_q != 4'd0) begin
      dec_o = ones_q - 4'd1;
    end else if (tens_q != 4'd0) begin
      dec_o = 4'd9;
      dec_t = tens_q - 4'd1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; priority is load > stop > start > en.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!load && !stop && start && !cnt_zero) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (load || stop) begin
          state_d = StIdle;
        end else if (en && cnt_one) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (load) begin
          state_d = StIdle;
        end else if (RELOAD && !pre_zero) begin
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Count and preset registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      pre_t_q <= 4'd0;
      pre_o_q <= 4'd0;
    end else begin
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      pre_t_q <= pre_t_d;
      pre_o_q <= pre_o_d;
    end
  end

  // Datapath next values: load in any state, decrement only in RUN, reload from DONE.
  always_comb begin
    tens_d  = tens_q;
    ones_d  = ones_q;
    pre_t_d = pre_t_q;
    pre_o_d = pre_o_q;
    if (load) begin
      tens_d  = load_t;
      ones_d  = load_o;
      pre_t_d = load_t;
      pre_o_d = load_o;
    end else begin
      unique case (state_q)
        StRun: begin
          // start is a no-op in RUN, so it does not mask the tick.
          if (!stop && en && !cnt_zero) begin
            tens_d = dec_t;
            ones_d = dec_o;
          end
        end
        StDone: begin
          if (RELOAD && !pre_zero) begin
            tens_d = pre_t_q;
            ones_d = pre_o_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registers only; no input-to-output path.
  always_comb begin
    tens    = tens_q;
    ones    = ones_q;
    running = (state_q == StRun);
    done    = (state_q == StDone);
  end

endmodule

// File: tb/tb_bcd_countdown.sv
// Bench for bcd_countdown: RELOAD=0 and RELOAD=1 instances share stimulus; a
// decimal reference model pushes expectations to a queue that is popped after each edge.
module tb_bcd_countdown;

  logic       clk;
  logic       reset;
  logic       load;
  logic [3:0] preset_tens;
  logic [3:0] preset_ones;
  logic       start;
  logic       stop;
  logic       en;
  logic [3:0] tens_w    [2];
  logic [3:0] ones_w    [2];
  logic       running_w [2];
  logic       done_w    [2];

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] t;
    logic [3:0] o;
    logic       r;
    logic       d;
  } exp_s;

  exp_s sb[$];

  // Reference model: count as an integer 0..99, states 0=idle 1=run 2=done.
  int m_cnt[2];
  int m_pre[2];
  int m_st [2];

  bcd_countdown #(.RELOAD(1'b0)) u_dut0 (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .preset_tens(preset_tens),
    .preset_ones(preset_ones),
    .start      (start),
    .stop       (stop),
    .en         (en),
    .tens       (tens_w[0]),
    .ones       (ones_w[0]),
    .running    (running_w[0]),
    .done       (done_w[0])
  );

  bcd_countdown #(.RELOAD(1'b1)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .preset_tens(preset_tens),
    .preset_ones(preset_ones),
    .start      (start),
    .stop       (stop),
    .en         (en),
    .tens       (tens_w[1]),
    .ones       (ones_w[1]),
    .running    (running_w[1]),
    .done       (done_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int r = 0; r < 2; r++) begin
      m_cnt[r] = 0;
      m_pre[r] = 0;
      m_st[r]  = 0;
    end
  endfunction

  function automatic void model_step(input int r, input logic ld, input logic [3:0] pt,
                                     input logic [3:0] po, input logic st, input logic sp,
                                     input logic e);
    int ct, co, lv;
    ct = (pt > 9) ? 9 : int'(pt);
    co = (po > 9) ? 9 : int'(po);
    lv = ct * 10 + co;
    case (m_st[r])
      0: begin
        if (ld) begin
          m_cnt[r] = lv;
          m_pre[r] = lv;
        end else if (!sp && st && m_cnt[r] != 0) begin
          m_st[r] = 1;
        end
      end
      1: begin
        if (ld) begin
          m_cnt[r] = lv;
          m_pre[r] = lv;
          m_st[r]  = 0;
        end else if (sp) begin
          m_st[r] = 0;
        end else if (e && m_cnt[r] > 0) begin
          m_cnt[r] = m_cnt[r] - 1;
          if (m_cnt[r] == 0) m_st[r] = 2;
        end
      end
      default: begin
        if (ld) begin
          m_cnt[r] = lv;
          m_pre[r] = lv;
          m_st[r]  = 0;
        end else if (r == 1 && m_pre[r] != 0) begin
          m_cnt[r] = m_pre[r];
          m_st[r]  = 1;
        end else begin
          m_st[r] = 0;
        end
      end
    endcase
  endfunction

  // Drive one cycle of inputs, queue model expectations, then compare after the edge.
  task automatic step(input logic ld, input logic [3:0] pt, input logic [3:0] po,
                      input logic st, input logic sp, input logic e, input string tag);
    exp_s x;
    load        = ld;
    preset_tens = pt;
    preset_ones = po;
    start       = st;
    stop        = sp;
    en          = e;
    for (int r = 0; r < 2; r++) begin
      model_step(r, ld, pt, po, st, sp, e);
      x.t = 4'(m_cnt[r] / 10);
      x.o = 4'(m_cnt[r] % 10);
      x.r = (m_st[r] == 1);
      x.d = (m_st[r] == 2);
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    for (int r = 0; r < 2; r++) begin
      x = sb.pop_front();
      chk($sformatf("%s[r%0d] count", tag, r), {tens_w[r], ones_w[r]}, {x.t, x.o});
      chk($sformatf("%s[r%0d] running", tag, r), {7'd0, running_w[r]}, {7'd0, x.r});
      chk($sformatf("%s[r%0d] done", tag, r), {7'd0, done_w[r]}, {7'd0, x.d});
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int r = 0; r < 2; r++) begin
      chk($sformatf("%s[r%0d] count", tag, r), {tens_w[r], ones_w[r]}, 8'h00);
      chk($sformatf("%s[r%0d] running", tag, r), {7'd0, running_w[r]}, 8'h00);
      chk($sformatf("%s[r%0d] done", tag, r), {7'd0, done_w[r]}, 8'h00);
    end
  endtask

  initial begin
    reset       = 1'b0;
    load        = 1'b0;
    preset_tens = 4'd0;
    preset_ones = 4'd0;
    start       = 1'b0;
    stop        = 1'b0;
    en          = 1'b0;
    model_reset();
    #3;
    chk_reset_vals("por");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Load 12 and run to zero with en held high.
    step(1'b1, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0, "load12");
    chk("load12 direct", {tens_w[0], ones_w[0]}, 8'h12);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, "start_en");
    chk("start_en no dec", {tens_w[0], ones_w[0]}, 8'h12);
    for (int i = 0; i < 12; i++) step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, "run12");
    chk("run12 done", {7'd0, done_w[0]}, 8'h01);
    chk("run12 zero", {tens_w[0], ones_w[0]}, 8'h00);
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, "after_done");
    chk("r0 idle after done", {7'd0, running_w[0]}, 8'h00);
    chk("r1 reloaded 12", {tens_w[1], ones_w[1]}, 8'h12);
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, "stop");
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, "start_at_00");
    chk("r0 start at 00 ignored", {7'd0, running_w[0]}, 8'h00);
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, "stop2");

    // Clamp and borrow.
    step(1'b1, 4'hC, 4'hF, 1'b0, 1'b0, 1'b0, "clamp");
    chk("clamp 99", {tens_w[0], ones_w[0]}, 8'h99);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, "start99");
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, "dec99");
    chk("dec to 96", {tens_w[0], ones_w[0]}, 8'h96);
    step(1'b1, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0, "load20");
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, "start20");
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, "borrow20");
    chk("borrow 19", {tens_w[0], ones_w[0]}, 8'h19);

    // Pause and priority.
    step(1'b1, 4'd3, 4'd5, 1'b0, 1'b0, 1'b0, "load35");
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, "start35");
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, "stop_en");
    chk("stop_en hold 35", {tens_w[0], ones_w[0]}, 8'h35);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, "restart35");
    step(1'b1, 4'd0, 4'd7, 1'b0, 1'b0, 1'b1, "load_en");
    chk("load_en 07", {tens_w[0], ones_w[0]}, 8'h07);
    step(1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, "load_start");
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, "start_00");

    // Auto-reload sequence from 03.
    step(1'b1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, "load03");
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, "start03");
    for (int i = 0; i < 10; i++) step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, "reload03");
    step(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, "load00");
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, "start_ign");
    chk("r1 start at 00 ignored", {7'd0, running_w[1]}, 8'h00);

    // Gapped enable from 10.
    step(1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, "load10");
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, "start10");
    for (int i = 0; i < 26; i++) step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, (i % 2) == 0, "gap");

    // Constrained-random mix against the model.
    for (int i = 0; i < 80; i++) begin
      step($urandom_range(0, 11) == 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
           "rand");
    end

    // Asynchronous reset mid-count at 47.
    step(1'b1, 4'd4, 4'd8, 1'b0, 1'b0, 1'b0, "load48");
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, "start48");
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, "to47");
    chk("at 47", {tens_w[0], ones_w[0]}, 8'h47);
    #1;
    reset = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    chk_reset_vals("held_rst");
    reset = 1'b1;
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, "post_rst");
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, "post_rst_start");
    chk("post reset idle", {7'd0, running_w[1]}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
